// File: rtl/byte_stream_reader_if.sv
// Byte stream reader bus interface.
// Bundles every signal of the reader except clk and reset.
//   Write port    : wr_data, wr_addr, store
//   Command port  : start, start_addr, length
//   Stream port   : out_data, out_valid, out_ready
//   Status        : busy, done
// Modports:
//   slave  - the reader's view (write/command/out_ready in, stream/status out)
//   master - the view of whoever drives the reader
interface byte_stream_reader_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              store;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  wr_data, wr_addr, store, start, start_addr, length, out_ready,
    output out_data, out_valid, busy, done
  );

  modport master (
    output wr_data, wr_addr, store, start, start_addr, length, out_ready,
    input  out_data, out_valid, busy, done
  );
endinterface

// File: rtl/byte_stream_reader.sv
// Byte stream reader.
// A DEPTH-byte register bank written one byte per clock, plus a read engine
// that, on a start command, streams `length` bytes from `start_addr` upward
// (wrapping mod DEPTH) on a valid/ready byte interface and then pulses done.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset (clears bank and engine)
//   bus    - byte_stream_reader_if.slave: write port, command port,
//            output stream (out_data/out_valid/out_ready), busy, done
module byte_stream_reader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  byte_stream_reader_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // Bank held as a flat vector so each byte can be its own register with
  // an asynchronous clear, while reads index it with a simple part-select.
  logic [DEPTH*8-1:0] bank_flat;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bank
      logic [7:0] byte_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          byte_reg <= 8'h00;
        end else if (bus.store && (bus.wr_addr == ADDR_W'(gi))) begin
          byte_reg <= bus.wr_data;
        end
      end

      assign bank_flat[gi*8 +: 8] = byte_reg;
    end
  endgenerate

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;        // address of the next byte to load
  logic [ADDR_W:0]   remaining_reg, remaining_next;  // bytes left, including the one presented
  logic [7:0]        data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  // Reads see the bank as it was before this edge's store, giving
  // read-first behaviour for a same-edge store and load.
  logic [7:0] start_byte;
  logic [7:0] ptr_byte;
  assign start_byte = bank_flat[bus.start_addr*8 +: 8];
  assign ptr_byte   = bank_flat[ptr_reg*8 +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            data_next      = start_byte;
            valid_next     = 1'b1;
            busy_next      = 1'b1;
            ptr_next       = bus.start_addr + 1'b1;
            remaining_next = bus.length;
            state_next     = READ;
          end else begin
            // Empty request completes immediately without any valid byte.
            done_next = 1'b1;
          end
        end
      end

      READ: begin
        // Without a transfer everything holds, which keeps out_data stable
        // through a stall even if the bank location is rewritten.
        if (valid_reg && bus.out_ready) begin
          if (remaining_reg == (ADDR_W+1)'(1)) begin
            valid_next     = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b1;
            remaining_next = '0;
            state_next     = IDLE;
          end else begin
            data_next      = ptr_byte;
            ptr_next       = ptr_reg + 1'b1;
            remaining_next = remaining_reg - 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.out_data  = data_reg;
  assign bus.out_valid = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_byte_stream_reader.sv
// Testbench for byte_stream_reader: scoreboard of expected bytes built from
// a reference copy of the bank, compared against the bytes actually accepted.
module tb_byte_stream_reader;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;

  byte_stream_reader_if #(.ADDR_W(ADDR_W)) bus ();

  byte_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_bank [DEPTH];
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];

  // stream statistics from the last collect call
  int first_valid, busy_cycles, done_count, done_cycle, last_xfer, valid_cycles;
  bit stall_changed, timed_out;

  task automatic store_byte(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.store   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    #1 bus.store = 1'b0;
    model_bank[a] = d;
  endtask

  task automatic push_expected(input logic [3:0] a, input int n);
    logic [3:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_bank[p]);
      p = p + 4'd1;
    end
  endtask

  task automatic start_cmd(input logic [3:0] a, input int len);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.length     = 5'(len);
    push_expected(a, len);
  endtask

  // Runs the consumer side for up to max_cycles, gathering accepted bytes
  // into obs_q and stream statistics; returns two cycles after done.
  task automatic collect(input int max_cycles, input int stall_idx,
                         input int stall_len, input bit inject_start);
    int stall_left;
    int cyc;
    int n_xfer;
    int tail;
    logic [7:0] held;
    bit holding;
    stall_left = stall_len;
    cyc = 0; n_xfer = 0; tail = -1; holding = 0; held = 8'h00;
    first_valid = -1; busy_cycles = 0; done_count = 0; done_cycle = -1;
    last_xfer = -1; valid_cycles = 0; stall_changed = 0; timed_out = 1;
    while (cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      bus.store = 1'b0;
      if (bus.out_valid && n_xfer == stall_idx && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
      if (bus.out_valid) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = cyc;
        if (holding && bus.out_data !== held) stall_changed = 1;
        if (!bus.out_ready) begin
          held = bus.out_data;
          holding = 1;
        end else begin
          holding = 0;
          obs_q.push_back(bus.out_data);
          n_xfer++;
          last_xfer = cyc;
        end
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = cyc;
      end
      if (inject_start && cyc == 2) begin
        bus.start      = 1'b1;
        bus.start_addr = 4'd0;
        bus.length     = 5'd5;
      end
      if (done_cycle >= 0 && tail < 0) tail = cyc + 2;
      if (cyc == tail) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] e, o;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) model_bank[i] = 8'h00;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b busy=%b done=%b data=%0h exp 0/0/0/00",
               bus.out_valid, bus.busy, bus.done, bus.out_data);
    end
    reset = 1'b0;
    start_cmd(4'd0, 4);
    collect(30, -1, 0, 0);
    checks++;
    if (timed_out || done_count != 1) begin
      failures++;
      $display("FAIL reset_read_done got count=%0d timeout=%0b exp 1/0", done_count, timed_out);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL reset_read_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_read_byte got=%0h exp=%0h", o, e); end
      $display("reset read byte %0h", o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_basic_stream();
    logic [7:0] e, o;
    for (int i = 0; i < 4; i++) store_byte(4'(2 + i), 8'(8'hA0 + i));
    start_cmd(4'd2, 4);
    collect(30, -1, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL basic_byte got=%0h exp=%0h", o, e); end
      $display("basic byte %0h", o);
    end
    checks++;
    if (first_valid != 1 || last_xfer != 4) begin
      failures++; $display("FAIL basic_timing got first=%0d last=%0d exp 1/4", first_valid, last_xfer);
    end
    checks++;
    if (done_cycle != 5 || done_count != 1) begin
      failures++; $display("FAIL basic_done got cycle=%0d count=%0d exp 5/1", done_cycle, done_count);
    end
    checks++;
    if (busy_cycles != 4) begin
      failures++; $display("FAIL basic_busy got=%0d exp=4", busy_cycles);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wrap();
    logic [7:0] e, o;
    store_byte(4'd14, 8'h11);
    store_byte(4'd15, 8'h22);
    store_byte(4'd0, 8'h33);
    start_cmd(4'd14, 3);
    collect(30, -1, 0, 0);
    checks++;
    if (obs_q.size() != exp_q.size() || done_cycle != 4) begin
      failures++; $display("FAIL wrap_count got n=%0d done=%0d exp n=%0d done=4", obs_q.size(), done_cycle, exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_byte got=%0h exp=%0h", o, e); end
      $display("wrap byte %0h", o);
    end
    exp_q.delete(); obs_q.delete();
    // longer than DEPTH: wrapped locations are read again
    start_cmd(4'd15, 17);
    collect(60, -1, 0, 0);
    checks++;
    if (obs_q.size() != 17 || done_cycle != 18) begin
      failures++; $display("FAIL long_count got n=%0d done=%0d exp 17/18", obs_q.size(), done_cycle);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL long_byte got=%0h exp=%0h", o, e); end
    end
    $display("long read of 17 bytes compared");
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stall();
    logic [7:0] e, o;
    start_cmd(4'd2, 3);
    collect(40, 1, 5, 0);
    checks++;
    if (stall_changed) begin
      failures++; $display("FAIL stall_hold got changed=1 exp changed=0");
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL stall_byte got=%0h exp=%0h", o, e); end
      $display("stall byte %0h", o);
    end
    checks++;
    if (last_xfer != 8 || done_cycle != 9 || valid_cycles != 8) begin
      failures++;
      $display("FAIL stall_timing got last=%0d done=%0d valid=%0d exp 8/9/8", last_xfer, done_cycle, valid_cycles);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_len0_and_ignored_start();
    logic [7:0] e, o;
    start_cmd(4'd3, 0);
    collect(20, -1, 0, 0);
    checks++;
    if (done_cycle != 1 || done_count != 1 || valid_cycles != 0) begin
      failures++;
      $display("FAIL len0 got done=%0d count=%0d valid=%0d exp 1/1/0", done_cycle, done_count, valid_cycles);
    end
    $display("len0 done at cycle %0d", done_cycle);
    start_cmd(4'd2, 3);
    collect(30, -1, 0, 1);
    checks++;
    if (obs_q.size() != 3 || done_count != 1 || done_cycle != 4) begin
      failures++;
      $display("FAIL ignored_start got n=%0d count=%0d done=%0d exp 3/1/4", obs_q.size(), done_count, done_cycle);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL ignored_byte got=%0h exp=%0h", o, e); end
      $display("ignored-start stream byte %0h", o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] e, o;
    int done_seen;
    done_seen = 0;
    start_cmd(4'd2, 4);
    exp_q.delete();
    @(negedge clk);
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_outputs got valid=%b busy=%b data=%0h exp 0/0/00", bus.out_valid, bus.busy, bus.out_data);
    end
    for (int i = 0; i < DEPTH; i++) model_bank[i] = 8'h00;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++; $display("FAIL midreset_done got=%0d exp=0", done_seen);
    end
    start_cmd(4'd2, 4);
    collect(30, -1, 0, 0);
    checks++;
    if (obs_q.size() != 4 || done_count != 1) begin
      failures++; $display("FAIL midreset_restart got n=%0d count=%0d exp 4/1", obs_q.size(), done_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL midreset_byte got=%0h exp=%0h", o, e); end
      $display("after-reset byte %0h", o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_same_edge_store_load();
    logic [7:0] e, o;
    store_byte(4'd7, 8'h5A);
    @(negedge clk);
    bus.store      = 1'b1;
    bus.wr_addr    = 4'd7;
    bus.wr_data    = 8'hC3;
    bus.start      = 1'b1;
    bus.start_addr = 4'd7;
    bus.length     = 5'd1;
    exp_q.push_back(model_bank[7]);
    model_bank[7] = 8'hC3;
    collect(20, -1, 0, 0);
    start_cmd(4'd7, 1);
    collect(20, -1, 0, 0);
    checks++;
    if (obs_q.size() != 2) begin
      failures++; $display("FAIL same_edge_count got=%0d exp=2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL same_edge_byte got=%0h exp=%0h", o, e); end
      $display("same-edge byte %0h", o);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    reset          = 1'b1;
    bus.wr_data    = 8'h00;
    bus.wr_addr    = '0;
    bus.store      = 1'b0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.length     = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_basic_stream();
    test_wrap();
    test_stall();
    test_len0_and_ignored_start();
    test_reset_mid_stream();
    test_same_edge_store_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
